// File: rtl/ball_ctrl.sv
//==============================================================================
// ball_ctrl : ball movement, bounce and serve control for the paddle game
// Revision  : 1.0  initial release
//==============================================================================
`default_nettype none

module ball_ctrl #(
    parameter int         MAX_X         = 640,
    parameter int         MAX_Y         = 480,
    parameter int         PADDLE_Y_LOW  = 470,
    parameter int         BALL_SIZE     = 8,
    parameter int         BALL_VELOCITY = 2,
    parameter logic [4:0] BALL_COLOR_r  = 5'b11111,
    parameter logic [5:0] BALL_COLOR_g  = 6'b111111,
    parameter logic [4:0] BALL_COLOR_b  = 5'b11111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ref_tick,
    input  logic        launch,
    input  logic        brick_hit,
    input  logic [10:0] paddle_left,
    input  logic [10:0] paddle_right,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic        ball_on,
    output logic [4:0]  ball_rgb_r,
    output logic [5:0]  ball_rgb_g,
    output logic [4:0]  ball_rgb_b,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        miss
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        MISS = 2'd2
    } state_t;

    localparam logic [10:0] c_size_m1    = 11'(BALL_SIZE - 1);
    localparam logic [10:0] c_half       = 11'(BALL_SIZE / 2);
    localparam logic [10:0] c_vel        = 11'(BALL_VELOCITY);
    localparam logic [10:0] c_right_lim  = 11'(MAX_X - 1 - BALL_VELOCITY);
    localparam logic [10:0] c_bottom_lim = 11'(MAX_Y - 1 - BALL_VELOCITY);
    localparam logic [10:0] c_pad_lo     = 11'(PADDLE_Y_LOW - BALL_VELOCITY);
    localparam logic [10:0] c_pad_hi     = 11'(PADDLE_Y_LOW - 1);
    localparam logic [10:0] c_serve_y    = 11'(PADDLE_Y_LOW - BALL_SIZE);

    state_t      r_state, w_state_nx;
    logic [10:0] r_ball_x, w_ball_x_nx;
    logic [10:0] r_ball_y, w_ball_y_nx;
    logic        r_dir_x, w_dir_x_nx;   // 1 = moving right
    logic        r_dir_y, w_dir_y_nx;   // 1 = moving up
    logic        r_brick, w_brick_nx;

    logic [10:0] w_right_edge;
    logic [10:0] w_bottom_edge;
    logic [10:0] w_paddle_w;
    logic [10:0] w_serve_x;
    logic        w_on_paddle;

    assign w_right_edge  = r_ball_x + c_size_m1;
    assign w_bottom_edge = r_ball_y + c_size_m1;
    assign w_paddle_w    = paddle_right - paddle_left + 11'd1;
    assign w_serve_x     = paddle_left + (w_paddle_w >> 1) - c_half;
    assign w_on_paddle   = !r_dir_y
                         && (w_bottom_edge >= c_pad_lo) && (w_bottom_edge <= c_pad_hi)
                         && (w_right_edge >= paddle_left) && (r_ball_x <= paddle_right);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ball_x <= 11'd0;
            r_ball_y <= c_serve_y;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_brick  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ball_x <= w_ball_x_nx;
            r_ball_y <= w_ball_y_nx;
            r_dir_x  <= w_dir_x_nx;
            r_dir_y  <= w_dir_y_nx;
            r_brick  <= w_brick_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_ball_x_nx = r_ball_x;
        w_ball_y_nx = r_ball_y;
        w_dir_x_nx  = r_dir_x;
        w_dir_y_nx  = r_dir_y;
        w_brick_nx  = r_brick;
        case (r_state)
            IDLE: begin
                w_brick_nx = 1'b0;
                if (ref_tick) begin
                    if (launch) begin
                        w_state_nx = PLAY;
                        w_dir_x_nx = 1'b1;
                        w_dir_y_nx = 1'b1;
                    end else begin
                        w_ball_x_nx = w_serve_x;
                        w_ball_y_nx = c_serve_y;
                    end
                end
            end
            PLAY: begin
                if (!ref_tick) begin
                    w_brick_nx = r_brick | brick_hit;
                end else begin
                    w_brick_nx = 1'b0;
                    if (w_bottom_edge >= c_bottom_lim) begin
                        w_state_nx = MISS;
                    end else begin
                        if (r_ball_x <= c_vel)
                            w_dir_x_nx = 1'b1;
                        else if (w_right_edge >= c_right_lim)
                            w_dir_x_nx = 1'b0;
                        // One vertical action per tick: paddle, then top, then brick
                        if (w_on_paddle)
                            w_dir_y_nx = 1'b1;
                        else if (r_ball_y <= c_vel)
                            w_dir_y_nx = 1'b0;
                        else if (r_brick || brick_hit)
                            w_dir_y_nx = ~r_dir_y;
                        w_ball_x_nx = w_dir_x_nx ? r_ball_x + c_vel : r_ball_x - c_vel;
                        w_ball_y_nx = w_dir_y_nx ? r_ball_y - c_vel : r_ball_y + c_vel;
                    end
                end
            end
            MISS: begin
                w_brick_nx = 1'b0;
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign ball_on = (pix_x >= r_ball_x) && (pix_x <= w_right_edge)
                  && (pix_y >= r_ball_y) && (pix_y <= w_bottom_edge);
    assign ball_rgb_r = BALL_COLOR_r;
    assign ball_rgb_g = BALL_COLOR_g;
    assign ball_rgb_b = BALL_COLOR_b;
    assign ball_x     = r_ball_x;
    assign ball_y     = r_ball_y;
    assign miss       = (r_state == MISS);

endmodule

`default_nettype wire

// File: tb/tb_ball_ctrl.sv
//==============================================================================
// tb_ball_ctrl : directed self-checking bench for ball_ctrl
// Revision     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ball_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ref_tick = 1'b0;
    logic        launch = 1'b0;
    logic        brick_hit = 1'b0;
    logic [10:0] paddle_left = 11'd200;
    logic [10:0] paddle_right = 11'd263;
    logic [10:0] pix_x = 11'd0;
    logic [10:0] pix_y = 11'd0;
    logic        ball_on;
    logic [4:0]  ball_rgb_r;
    logic [5:0]  ball_rgb_g;
    logic [4:0]  ball_rgb_b;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic        miss;

    int n_checks = 0;
    int n_errors = 0;
    int miss_cnt = 0;

    ball_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ref_tick     (ref_tick),
        .launch       (launch),
        .brick_hit    (brick_hit),
        .paddle_left  (paddle_left),
        .paddle_right (paddle_right),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .ball_on      (ball_on),
        .ball_rgb_r   (ball_rgb_r),
        .ball_rgb_g   (ball_rgb_g),
        .ball_rgb_b   (ball_rgb_b),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .miss         (miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (miss === 1'b1) miss_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 32'(ball_x), 32'(ex));
        check({tag, "_y"}, 32'(ball_y), 32'(ey));
    endtask

    // One ref_tick cycle followed by one quiet cycle; ends 1 time unit after an edge
    task automatic do_tick(input logic l);
        ref_tick = 1'b1;
        launch   = l;
        @(posedge clk); #1;
        ref_tick = 1'b0;
        launch   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick(1'b0);
    endtask

    task automatic pix_check(input string tag, input int px, input int py, input logic exp);
        pix_x = 11'(px);
        pix_y = 11'(py);
        #1;
        check(tag, 32'(ball_on), 32'(exp));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        check("rst_x", 32'(ball_x), 32'd0);
        check("rst_y", 32'(ball_y), 32'd462);
        check("rst_miss", 32'(miss), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        // ---------------- serve, launch, bricks, mid-play reset ----------------
        #2;
        apply_reset();
        check("miss_cnt_init", 32'(miss_cnt), 32'd0);

        do_tick(1'b0);
        check_pos("center", 228, 462);
        pix_check("on_tl",    228, 462, 1'b1);
        pix_check("on_br",    235, 469, 1'b1);
        pix_check("off_r",    236, 465, 1'b0);
        pix_check("off_l",    227, 465, 1'b0);
        pix_check("off_b",    230, 470, 1'b0);
        pix_check("off_t",    230, 461, 1'b0);
        check("rgb_r", 32'(ball_rgb_r), 32'd31);
        check("rgb_g", 32'(ball_rgb_g), 32'd63);
        check("rgb_b", 32'(ball_rgb_b), 32'd31);

        do_tick(1'b1);
        check_pos("launch", 228, 462);
        ticks(3);
        check_pos("three", 234, 456);

        brick_hit = 1'b1;
        @(posedge clk); #1;
        brick_hit = 1'b0;
        @(posedge clk); #1;
        check_pos("hold", 234, 456);
        do_tick(1'b0);
        check_pos("brick_flag", 236, 458);

        ref_tick  = 1'b1;
        brick_hit = 1'b1;
        @(posedge clk); #1;
        ref_tick  = 1'b0;
        brick_hit = 1'b0;
        @(posedge clk); #1;
        check_pos("brick_same", 238, 456);
        do_tick(1'b0);
        check_pos("flag_clr", 240, 454);

        reset = 1'b1;
        #1;
        check_pos("midrst", 0, 462);
        check("midrst_miss", 32'(miss), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("miss_cnt_a", 32'(miss_cnt), 32'd0);
        do_tick(1'b0);
        check_pos("idle_after_rst", 228, 462);

        // ---------------- walls, top, bottom miss ----------------
        paddle_left  = 11'd600;
        paddle_right = 11'd647;
        do_tick(1'b0);
        check_pos("center_b", 620, 462);
        do_tick(1'b1);
        ticks(5);
        check_pos("pre_rwall", 630, 452);
        ticks(1);
        check_pos("rwall", 628, 450);
        ticks(224);
        check_pos("pre_top", 180, 2);
        ticks(1);
        check_pos("top", 178, 4);
        ticks(88);
        check_pos("pre_lwall", 2, 180);
        ticks(1);
        check_pos("lwall", 4, 182);
        ticks(144);
        check_pos("pre_miss", 292, 470);
        check("miss_cnt_b0", 32'(miss_cnt), 32'd0);

        ref_tick = 1'b1;
        @(posedge clk); #1;
        ref_tick = 1'b0;
        check("miss_hi", 32'(miss), 32'd1);
        check_pos("miss_hold", 292, 470);
        @(posedge clk); #1;
        check("miss_lo", 32'(miss), 32'd0);
        check("miss_cnt_b1", 32'(miss_cnt), 32'd1);
        do_tick(1'b0);
        check_pos("recenter", 620, 462);

        // ---------------- paddle bounce ----------------
        apply_reset();
        do_tick(1'b0);
        do_tick(1'b1);
        ticks(460);
        check_pos("pre_paddle", 284, 462);
        paddle_left  = 11'd250;
        paddle_right = 11'd313;
        do_tick(1'b0);
        check_pos("paddle", 286, 460);
        do_tick(1'b0);
        check_pos("paddle_up", 288, 458);
        check("miss_cnt_c", 32'(miss_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
